// File: rtl/mem_clk_pkg.sv
// rtl/mem_clk_pkg.sv - shared state encoding and default timing for memory bank clock gating
package mem_clk_pkg;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_WAKE  = 2'd1,
    S_ON    = 2'd2,
    S_DRAIN = 2'd3
  } gate_state_e;

  localparam int DEF_IDLE_CYCLES = 16;
  localparam int DEF_WAKE_CYCLES = 2;
  localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/mem_clk_cnt.sv
// rtl/mem_clk_cnt.sv - loadable down-counter with zero flag, shared by wake and idle timing
module mem_clk_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Load takes priority; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_clk_gate_ctrl.sv
// rtl/mem_clk_gate_ctrl.sv - demand-driven clock-enable controller for a memory bank
// Optional CLKGATE_BYPASS_EN adds force_on, which pins the bank clock on while high.
module mem_clk_gate_ctrl #(
  parameter int IDLE_CYCLES = mem_clk_pkg::DEF_IDLE_CYCLES,
  parameter int WAKE_CYCLES = mem_clk_pkg::DEF_WAKE_CYCLES,
  parameter int CNT_W       = mem_clk_pkg::DEF_CNT_W
) (
  input  logic mclk,
  input  logic rst,
  input  logic req,
`ifdef CLKGATE_BYPASS_EN
  input  logic force_on,
`endif
  output logic ready,
  output logic clk_en,
  output logic gated_off
);

  import mem_clk_pkg::*;

  localparam logic [CNT_W-1:0] IDLE_RELOAD = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_RELOAD = CNT_W'(WAKE_CYCLES - 1);

  gate_state_e      state_d, state_q;
  logic             clk_en_d, clk_en_q;
  logic             ready_d, ready_q;
  logic             gated_off_d, gated_off_q;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             hold;
  logic             wake_req;
  logic             accept;

`ifdef CLKGATE_BYPASS_EN
  assign hold = force_on;
`else
  assign hold = 1'b0;
`endif

  assign wake_req = req || hold;
  // Acceptance uses the registered ready, so req never reaches an output combinationally.
  assign accept   = req && ready_q;

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_val  = IDLE_RELOAD;
    cnt_dec  = 1'b0;
    case (state_q)
      S_OFF: begin
        if (wake_req) begin
          state_d  = S_WAKE;
          cnt_load = 1'b1;
          cnt_val  = WAKE_RELOAD;
        end
      end
      S_WAKE: begin
        if (cnt_zero) begin
          state_d  = S_ON;
          cnt_load = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_ON: begin
        // An accept on the cycle the timer expires still keeps the bank on.
        if (accept || hold) begin
          cnt_load = 1'b1;
        end else if (cnt_zero) begin
          state_d = S_DRAIN;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_DRAIN: begin
        if (wake_req) begin
          state_d  = S_ON;
          cnt_load = 1'b1;
        end else begin
          state_d = S_OFF;
        end
      end
      default: state_d = S_OFF;
    endcase

    clk_en_d    = (state_d != S_OFF);
    ready_d     = (state_d == S_ON);
    gated_off_d = (state_d == S_OFF);
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      state_q     <= S_OFF;
      clk_en_q    <= 1'b0;
      ready_q     <= 1'b0;
      gated_off_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      clk_en_q    <= clk_en_d;
      ready_q     <= ready_d;
      gated_off_q <= gated_off_d;
    end
  end

  mem_clk_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .mclk    (mclk),
    .rst     (rst),
    .load    (cnt_load),
    .load_val(cnt_val),
    .dec     (cnt_dec),
    .zero    (cnt_zero)
  );

  assign clk_en    = clk_en_q;
  assign ready     = ready_q;
  assign gated_off = gated_off_q;

endmodule

// File: tb/tb_mem_clk_gate_ctrl.sv
// tb/tb_mem_clk_gate_ctrl.sv - directed bench for mem_clk_gate_ctrl at default parameters
module tb_mem_clk_gate_ctrl;

  typedef struct {
    logic rst;
    logic req;
    logic en;
    logic rdy;
    logic off;
  } vec_t;

  logic mclk;
  logic rst;
  logic req;
  logic ready;
  logic clk_en;
  logic gated_off;
`ifdef CLKGATE_BYPASS_EN
  logic force_on;
`endif

  int n_cmp;
  int n_err;
  vec_t vecs[10];

  mem_clk_gate_ctrl dut (
    .mclk     (mclk),
    .rst      (rst),
    .req      (req),
`ifdef CLKGATE_BYPASS_EN
    .force_on (force_on),
`endif
    .ready    (ready),
    .clk_en   (clk_en),
    .gated_off(gated_off)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic check(input string nm, input logic e_en, input logic e_rdy, input logic e_off);
    n_cmp++;
    if ({clk_en, ready, gated_off} !== {e_en, e_rdy, e_off}) begin
      n_err++;
      $display("FAIL %s: got clk_en/ready/gated_off=%b%b%b want %b%b%b",
               nm, clk_en, ready, gated_off, e_en, e_rdy, e_off);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 1'b0;
    tick();
    check("reset", 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
  endtask

  // From OFF: clk_en rises after the first edge, ready two edges later; req left high.
  task automatic wake_up(input string nm);
    req = 1'b1;
    tick();
    check(nm, 1'b1, 1'b0, 1'b0);
    tick();
    check(nm, 1'b1, 1'b0, 1'b0);
    tick();
    check(nm, 1'b1, 1'b1, 1'b0);
  endtask

  // Called right after a reload edge: 15 more ready cycles, DRAIN on the 16th, OFF on the 17th.
  task automatic idle_run(input string nm, input bit to_off);
    req = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check(nm, 1'b1, 1'b1, 1'b0);
    end
    tick();
    check({nm, "_drain"}, 1'b1, 1'b0, 1'b0);
    if (to_off) begin
      tick();
      check({nm, "_off"}, 1'b0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    req   = 1'b0;
`ifdef CLKGATE_BYPASS_EN
    force_on = 1'b0;
`endif

    // rst, req -> clk_en, ready, gated_off after the edge
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 10; i++) begin
      rst = vecs[i].rst;
      req = vecs[i].req;
      tick();
      check($sformatf("vec%0d", i), vecs[i].en, vecs[i].rdy, vecs[i].off);
    end

    // Idle after reset stays gated.
    do_reset();
    for (int i = 0; i < 50; i++) begin
      tick();
      check("idle_off", 1'b0, 1'b0, 1'b1);
    end

    // Wake latency, single accept, then full idle timeout to OFF.
    wake_up("wake");
    tick();
    check("accept", 1'b1, 1'b1, 1'b0);
    idle_run("timeout", 1'b1);

    // Request arriving in DRAIN returns straight to ON and restarts the idle timer.
    wake_up("wake2");
    tick();
    check("accept2", 1'b1, 1'b1, 1'b0);
    idle_run("pre_drain", 1'b0);
    req = 1'b1;
    tick();
    check("drain_to_on", 1'b1, 1'b1, 1'b0);
    tick();
    check("drain_accept", 1'b1, 1'b1, 1'b0);
    idle_run("restart", 1'b1);

    // Accept exactly when the timer hits zero keeps the bank on.
    wake_up("wake3");
    tick();
    check("accept3", 1'b1, 1'b1, 1'b0);
    for (int r = 0; r < 12; r++) begin
      req = 1'b0;
      for (int k = 0; k < 15; k++) begin
        tick();
        check("steady", 1'b1, 1'b1, 1'b0);
      end
      req = 1'b1;
      tick();
      check("accept_at_zero", 1'b1, 1'b1, 1'b0);
    end
    idle_run("steady_end", 1'b1);

    // Reset mid-WAKE and mid-ON drops the enable at that edge.
    req = 1'b1;
    tick();
    check("wake_b", 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    check("rst_in_wake", 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    wake_up("wake4");
    rst = 1'b1;
    tick();
    check("rst_in_on", 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    req = 1'b0;

`ifdef CLKGATE_BYPASS_EN
    do_reset();
    force_on = 1'b1;
    tick();
    check("force_wake", 1'b1, 1'b0, 1'b0);
    tick();
    check("force_wake", 1'b1, 1'b0, 1'b0);
    tick();
    check("force_on", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) begin
      tick();
      check("force_hold", 1'b1, 1'b1, 1'b0);
    end
    force_on = 1'b0;
    idle_run("force_release", 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
